l2_assoc_cache: RTL and testbench
=================================

// Module: l2_assoc_cache
// PURPOSE
//  Parametrised N-way set-associative L2 data cache with per-set true-LRU replacement, valid/ready request handshake and victim eviction port.
//  Sits between the L1 miss path and the memory interface. Write hit updates in place; write miss allocates, evicting the LRU line when the set is full.
//  Read miss does not allocate. Adds flush and saturating hit/miss statistics.
// PARAMETERS
//  ADDR_W      32  request address width (byte address)
//  DATA_W      32  data word width
//  OFFSET_BITS 2   byte-offset bits ignored for lookup
//  INDEX_BITS  4   set index bits; SETS = 2**INDEX_BITS
//  WAYS        4   associativity, power of 2, >=2; AGE_W = $clog2(WAYS)
//  CNT_W       16  statistics counter width
//  TAG_W = ADDR_W-INDEX_BITS-OFFSET_BITS (localparam); index = addr[OFFSET_BITS+:INDEX_BITS]; tag = addr[ADDR_W-1-:TAG_W]
// PORTS
//  clk          in   1       clock
//  rst          in   1       async reset, active-high
//  req_valid    in   1       request present
//  req_ready    out  1       block can accept request (high only in IDLE, not flushing)
//  req_we       in   1       1 = write, 0 = read
//  req_addr     in   ADDR_W  request address
//  req_wdata    in   DATA_W  write data
//  rsp_valid    out  1       one-cycle response pulse
//  rsp_hit      out  1       lookup hit (write miss reports 0)
//  rsp_rdata    out  DATA_W  read data on read hit, write data on write, else 0
//  evict_valid  out  1       one-cycle pulse: valid line displaced
//  evict_addr   out  ADDR_W  {victim tag, index, OFFSET_BITS'0}
//  evict_data   out  DATA_W  victim data
//  flush        in   1       invalidate all lines (sampled in IDLE)
//  flush_done   out  1       one-cycle pulse when flush completes
//  hit_cnt      out  CNT_W   saturating hit counter
//  miss_cnt     out  CNT_W   saturating miss counter
// BEHAVIOUR
//  Reset: all outputs 0 except req_ready=1 after reset deassert; all valid bits 0; set ages[w]=w; counters 0; state IDLE.
//  FSM IDLE -> LOOKUP -> RESP -> IDLE; FLUSH entered from IDLE.
//  IDLE: flush=1 has priority over req_valid -> FLUSH (req_ready=0 that cycle). Else req_valid&&req_ready latches we/addr/wdata -> LOOKUP.
//  LOOKUP: compare tag with all valid ways in parallel; at most one match (invariant).
//   read hit: capture data, touch way. read miss: no state change.
//   write hit: overwrite data, touch way. write miss: victim = lowest-index invalid way, else way with age==WAYS-1; write {1,tag,data}, touch victim;
//   if victim was valid, evict_valid=1 in RESP with its tag/data.
//  RESP: rsp_valid=1 for exactly one cycle; latency acceptance->rsp_valid = 2 cycles; throughput 1 request / 3 cycles.
//  Touch(w): ages of ways with age < age[w] increment, age[w]=0; ages in a set always a permutation of 0..WAYS-1.
//  Counters: hit or miss incremented in RESP; saturate at all-ones, no wrap.
//  FLUSH: clears all valid bits and restores ages in one cycle; flush_done pulses next cycle (back in IDLE); no eviction pulses on flush.
//  Reset mid-operation: in-flight request dropped, no response, no eviction pulse.
//  Outputs registered; rsp_* / evict_* undefined-free: 0 whenever their valid is 0.
// STRUCTURE
//  Package l2_pkg: state_t enum {IDLE,LOOKUP,RESP,FLUSH}; line_t struct {valid, tag, data} parametrised via localparams; victim-address helper function.
//  Sub-module l2_lru_ctrl: per-set age storage, touch port (set, way), victim query (set) -> way, reset/flush restore.
//  Storage: line_t array [SETS][WAYS] in flops; no SRAM macro.
// TESTING
//  1 write 0x0000_0040 data 0xA5A5_0001, read same -> rsp 2 cycles after accept, hit=1, rdata=0xA5A5_0001, hit_cnt=1 miss_cnt=1.
//  2 read unmapped 0x0000_1000 -> rsp_hit=0, rdata=0, no allocation (re-read still misses).
//  3 fill set 0 with 4 tags (addr 0x000,0x040,0x080,0x0C0), read 0x000, write 0x100 -> evict_valid, evict_addr=0x040.
//  4 write hit 0x080 with 0x1234 then read -> 0x1234, no evict pulse.
//  5 flush while req_valid held -> req_ready=0, flush_done pulse, prior lines all miss afterwards.
//  6 assert rst during LOOKUP -> no rsp_valid, all outputs 0; miss_cnt forced near all-ones saturates.

Source files
------------

// File: rtl/l2_pkg.sv
// Shared types and constants for the L2 set-associative cache: FSM states,
// the line record and the address rebuild helper used for evictions.
package l2_pkg;

  localparam int L2_ADDR_W      = 32;
  localparam int L2_DATA_W      = 32;
  localparam int L2_OFFSET_BITS = 2;
  localparam int L2_INDEX_BITS  = 4;
  localparam int L2_WAYS        = 4;
  localparam int L2_CNT_W       = 16;
  localparam int L2_TAG_W       = L2_ADDR_W - L2_INDEX_BITS - L2_OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [L2_TAG_W-1:0]  tag;
    logic [L2_DATA_W-1:0] data;
  } line_t;

  // Rebuild the line-aligned byte address of a displaced line.
  function automatic logic [L2_ADDR_W-1:0] victim_addr(
    input logic [L2_TAG_W-1:0]      tag,
    input logic [L2_INDEX_BITS-1:0] index
  );
    return {tag, index, {L2_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/l2_lru_ctrl.sv
// Per-set true-LRU age tracking: age 0 is most recent, age WAYS-1 is the victim.
// Ages in every set stay a permutation of 0..WAYS-1.
module l2_lru_ctrl
  import l2_pkg::*;
#(
  parameter int INDEX_BITS = L2_INDEX_BITS,
  parameter int WAYS       = L2_WAYS,
  parameter int AGE_W      = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  restore,
  input  logic                  touch_en,
  input  logic [INDEX_BITS-1:0] touch_set,
  input  logic [AGE_W-1:0]      touch_way,
  input  logic [INDEX_BITS-1:0] query_set,
  output logic [AGE_W-1:0]      victim_way
);

  localparam int SETS = 2**INDEX_BITS;

  logic [AGE_W-1:0] ages [SETS][WAYS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          ages[s][w] <= AGE_W'(w);
    end else if (restore) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          ages[s][w] <= AGE_W'(w);
    end else if (touch_en) begin
      // Everything younger than the touched way ages by one; touched way becomes 0.
      for (int w = 0; w < WAYS; w++)
        if (ages[touch_set][w] < ages[touch_set][touch_way])
          ages[touch_set][w] <= ages[touch_set][w] + 1'b1;
      ages[touch_set][touch_way] <= '0;
    end
  end

  always_comb begin
    victim_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (ages[query_set][w] == AGE_W'(WAYS - 1))
        victim_way = AGE_W'(w);
  end

endmodule

// File: rtl/l2_assoc_cache.sv
// N-way set-associative L2 data cache with true-LRU replacement, write-allocate,
// read-no-allocate, victim eviction port, flush and saturating hit/miss counters.
module l2_assoc_cache
  import l2_pkg::*;
#(
  parameter int ADDR_W      = L2_ADDR_W,
  parameter int DATA_W      = L2_DATA_W,
  parameter int OFFSET_BITS = L2_OFFSET_BITS,
  parameter int INDEX_BITS  = L2_INDEX_BITS,
  parameter int WAYS        = L2_WAYS,
  parameter int CNT_W       = L2_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              evict_valid,
  output logic [ADDR_W-1:0] evict_addr,
  output logic [DATA_W-1:0] evict_data,
  input  logic              flush,
  output logic              flush_done,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [1:0]        dbg_state
);

  localparam int TAG_W = ADDR_W - INDEX_BITS - OFFSET_BITS;
  localparam int SETS  = 2**INDEX_BITS;
  localparam int AGE_W = $clog2(WAYS);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE with no flush pending, so one request per 3 cycles.

  state_t state, state_nx;

  line_t lines [SETS][WAYS];

  logic                  lat_we;
  logic [TAG_W-1:0]      lat_tag;
  logic [INDEX_BITS-1:0] lat_idx;
  logic [DATA_W-1:0]     lat_wdata;

  logic             hit, has_inv;
  logic [AGE_W-1:0] hit_way, inv_way, lru_way, alloc_way;
  line_t            victim_line;
  logic             touch_en;
  logic             unused_offset;

  assign unused_offset = ^req_addr[OFFSET_BITS-1:0];
  assign dbg_state     = state;
  assign req_ready     = !rst && (state == IDLE) && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (flush)          state_nx = FLUSH;
        else if (req_valid) state_nx = LOOKUP;
      end
      LOOKUP:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      FLUSH:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Parallel tag compare plus lowest-index invalid way search.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (lines[lat_idx][w].valid && (lines[lat_idx][w].tag == lat_tag)) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
    for (int w = WAYS - 1; w >= 0; w--)
      if (!lines[lat_idx][w].valid) begin
        has_inv = 1'b1;
        inv_way = AGE_W'(w);
      end
  end

  assign alloc_way   = has_inv ? inv_way : lru_way;
  assign victim_line = lines[lat_idx][alloc_way];
  assign touch_en    = (state == LOOKUP) && (hit || lat_we);

  l2_lru_ctrl #(
    .INDEX_BITS (INDEX_BITS),
    .WAYS       (WAYS),
    .AGE_W      (AGE_W)
  ) u_lru (
    .clk        (clk),
    .rst        (rst),
    .restore    (state == FLUSH),
    .touch_en   (touch_en),
    .touch_set  (lat_idx),
    .touch_way  (hit ? hit_way : alloc_way),
    .query_set  (lat_idx),
    .victim_way (lru_way)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          lines[s][w] <= '0;
      lat_we      <= 1'b0;
      lat_tag     <= '0;
      lat_idx     <= '0;
      lat_wdata   <= '0;
      rsp_valid   <= 1'b0;
      rsp_hit     <= 1'b0;
      rsp_rdata   <= '0;
      evict_valid <= 1'b0;
      evict_addr  <= '0;
      evict_data  <= '0;
      flush_done  <= 1'b0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
    end else begin
      // Pulse outputs default low so their payloads read 0 when not valid.
      rsp_valid   <= 1'b0;
      rsp_hit     <= 1'b0;
      rsp_rdata   <= '0;
      evict_valid <= 1'b0;
      evict_addr  <= '0;
      evict_data  <= '0;
      flush_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (!flush && req_valid) begin
            lat_we    <= req_we;
            lat_tag   <= req_addr[ADDR_W-1 -: TAG_W];
            lat_idx   <= req_addr[OFFSET_BITS +: INDEX_BITS];
            lat_wdata <= req_wdata;
          end
        end
        LOOKUP: begin
          rsp_valid <= 1'b1;
          rsp_hit   <= hit;
          if (lat_we) begin
            rsp_rdata <= lat_wdata;
            if (hit) begin
              lines[lat_idx][hit_way].data <= lat_wdata;
            end else begin
              lines[lat_idx][alloc_way] <= '{valid: 1'b1, tag: lat_tag, data: lat_wdata};
              if (victim_line.valid) begin
                evict_valid <= 1'b1;
                evict_addr  <= victim_addr(victim_line.tag, lat_idx);
                evict_data  <= victim_line.data;
              end
            end
          end else if (hit) begin
            rsp_rdata <= lines[lat_idx][hit_way].data;
          end
        end
        RESP: begin
          if (rsp_hit) begin
            if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
          end else begin
            if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
          end
        end
        FLUSH: begin
          for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
              lines[s][w].valid <= 1'b0;
          flush_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_assoc_cache.sv
// Directed bench for l2_assoc_cache: hit/miss, allocation, LRU eviction,
// write hit, flush, reset mid-request and counter saturation (CNT_W=4).
module tb_l2_assoc_cache;

  localparam int CNT_W = 4;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_hit;
  logic [31:0] rsp_rdata;
  logic        evict_valid;
  logic [31:0] evict_addr;
  logic [31:0] evict_data;
  logic        flush;
  logic        flush_done;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_fail;

  logic        r_hit;
  logic [31:0] r_rdata;
  logic        r_ev_valid;
  logic [31:0] r_ev_addr;
  logic [31:0] r_ev_data;
  int          r_lat;

  l2_assoc_cache #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_hit     (rsp_hit),
    .rsp_rdata   (rsp_rdata),
    .evict_valid (evict_valid),
    .evict_addr  (evict_addr),
    .evict_data  (evict_data),
    .flush       (flush),
    .flush_done  (flush_done),
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt),
    .dbg_state   (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge after the response cycle.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int i;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    i = 0;
    while (req_ready !== 1'b1 && i < 10) begin
      @(negedge clk);
      i++;
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_timeout addr=%h req_ready=%b expected 1", addr, req_ready);
      req_valid = 1'b0;
      r_hit = 1'bx; r_rdata = 'x; r_ev_valid = 1'bx; r_ev_addr = 'x; r_ev_data = 'x;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    r_lat = 1;
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ready addr=%h got=%b expected 0", addr, req_ready);
    end
    while (rsp_valid !== 1'b1 && r_lat < 10) begin
      @(negedge clk);
      r_lat++;
    end
    r_hit      = rsp_hit;
    r_rdata    = rsp_rdata;
    r_ev_valid = evict_valid;
    r_ev_addr  = evict_addr;
    r_ev_data  = evict_data;
    n_checks++;
    if (r_lat != 2) begin
      n_fail++;
      $display("FAIL latency addr=%h got=%0d expected 2", addr, r_lat);
    end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rsp_pulse addr=%h rsp_valid=%b expected 0", addr, rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid, rsp_hit, evict_valid, flush_done} !== 5'b0 ||
        rsp_rdata !== 32'h0 || evict_addr !== 32'h0 || hit_cnt !== 4'h0 || miss_cnt !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_outputs ready=%b rsp=%b ev=%b fd=%b hc=%0d mc=%0d expected all 0",
               req_ready, rsp_valid, evict_valid, flush_done, hit_cnt, miss_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready got=%b expected 1", req_ready);
    end
  endtask

  task automatic test_write_read();
    do_req(1'b1, 32'h0000_0040, 32'hA5A5_0001);
    n_checks++;
    if (r_hit !== 1'b0 || r_rdata !== 32'hA5A5_0001 || r_ev_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_miss hit=%b rdata=%h ev=%b expected 0 a5a50001 0", r_hit, r_rdata, r_ev_valid);
    end
    do_req(1'b0, 32'h0000_0040, 32'h0);
    n_checks++;
    if (r_hit !== 1'b1 || r_rdata !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL rd_hit hit=%b rdata=%h expected 1 a5a50001", r_hit, r_rdata);
    end
    n_checks++;
    if (hit_cnt !== 4'd1 || miss_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL cnt_t1 hit_cnt=%0d miss_cnt=%0d expected 1 1", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_read_miss();
    for (int i = 0; i < 2; i++) begin
      do_req(1'b0, 32'h0000_1000, 32'h0);
      n_checks++;
      if (r_hit !== 1'b0 || r_rdata !== 32'h0 || r_ev_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rd_miss_%0d hit=%b rdata=%h ev=%b expected 0 0 0", i, r_hit, r_rdata, r_ev_valid);
      end
    end
    n_checks++;
    if (miss_cnt !== 4'd3) begin
      n_fail++;
      $display("FAIL cnt_t2 miss_cnt=%0d expected 3", miss_cnt);
    end
  endtask

  task automatic test_evict();
    logic [31:0] fill_addr [4];
    fill_addr[0] = 32'h000; fill_addr[1] = 32'h040; fill_addr[2] = 32'h080; fill_addr[3] = 32'h0C0;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b1, fill_addr[i], 32'h1000 + fill_addr[i]);
      n_checks++;
      if (r_ev_valid !== 1'b0 || r_rdata !== 32'h1000 + fill_addr[i]) begin
        n_fail++;
        $display("FAIL fill_%0d ev=%b rdata=%h expected 0 %h", i, r_ev_valid, r_rdata, 32'h1000 + fill_addr[i]);
      end
    end
    do_req(1'b0, 32'h000, 32'h0);
    n_checks++;
    if (r_hit !== 1'b1 || r_rdata !== 32'h1000) begin
      n_fail++;
      $display("FAIL rd_000 hit=%b rdata=%h expected 1 00001000", r_hit, r_rdata);
    end
    // 0x040 is now least recently used and must be displaced.
    do_req(1'b1, 32'h100, 32'h1100);
    n_checks++;
    if (r_hit !== 1'b0 || r_ev_valid !== 1'b1 || r_ev_addr !== 32'h040 || r_ev_data !== 32'h1040) begin
      n_fail++;
      $display("FAIL evict hit=%b ev=%b addr=%h data=%h expected 0 1 00000040 00001040",
               r_hit, r_ev_valid, r_ev_addr, r_ev_data);
    end
    do_req(1'b0, 32'h040, 32'h0);
    n_checks++;
    if (r_hit !== 1'b0 || r_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rd_evicted hit=%b rdata=%h expected 0 0", r_hit, r_rdata);
    end
    do_req(1'b0, 32'h100, 32'h0);
    n_checks++;
    if (r_hit !== 1'b1 || r_rdata !== 32'h1100) begin
      n_fail++;
      $display("FAIL rd_100 hit=%b rdata=%h expected 1 00001100", r_hit, r_rdata);
    end
  endtask

  task automatic test_write_hit();
    do_req(1'b1, 32'h080, 32'h1234);
    n_checks++;
    if (r_hit !== 1'b1 || r_ev_valid !== 1'b0 || r_rdata !== 32'h1234 || r_ev_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wr_hit hit=%b ev=%b rdata=%h evaddr=%h expected 1 0 00001234 0",
               r_hit, r_ev_valid, r_rdata, r_ev_addr);
    end
    do_req(1'b0, 32'h080, 32'h0);
    n_checks++;
    if (r_hit !== 1'b1 || r_rdata !== 32'h1234) begin
      n_fail++;
      $display("FAIL rd_after_wr hit=%b rdata=%h expected 1 00001234", r_hit, r_rdata);
    end
    n_checks++;
    if (hit_cnt !== 4'd6 || miss_cnt !== 4'd8) begin
      n_fail++;
      $display("FAIL cnt_t4 hit_cnt=%0d miss_cnt=%0d expected 6 8", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_flush();
    flush = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h080; req_wdata = '0;
    #1;
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_ready_idle got=%b expected 0", req_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if (req_ready !== 1'b0 || flush_done !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_busy ready=%b done=%b expected 0 0", req_ready, flush_done);
    end
    @(negedge clk);
    n_checks++;
    if (flush_done !== 1'b1 || evict_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_done done=%b ev=%b expected 1 0", flush_done, evict_valid);
    end
    do_req(1'b0, 32'h080, 32'h0);
    n_checks++;
    if (r_hit !== 1'b0 || r_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL flush_miss_080 hit=%b rdata=%h expected 0 0", r_hit, r_rdata);
    end
    do_req(1'b0, 32'h000, 32'h0);
    n_checks++;
    if (r_hit !== 1'b0 || miss_cnt !== 4'd10 || hit_cnt !== 4'd6) begin
      n_fail++;
      $display("FAIL flush_miss_000 hit=%b hc=%0d mc=%0d expected 0 6 10", r_hit, hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_reset_mid_and_saturate();
    int seen;
    req_we = 1'b1; req_addr = 32'h0C0; req_wdata = 32'hDEAD_0001; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if (dbg_state !== 2'd1) begin
      n_fail++;
      $display("FAIL in_lookup state=%0d expected 1", dbg_state);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({rsp_valid, rsp_hit, evict_valid, flush_done, req_ready} !== 5'b0 ||
        rsp_rdata !== 32'h0 || hit_cnt !== 4'h0 || miss_cnt !== 4'h0) begin
      n_fail++;
      $display("FAIL rst_mid rsp=%b ev=%b ready=%b hc=%0d mc=%0d expected all 0",
               rsp_valid, evict_valid, req_ready, hit_cnt, miss_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid === 1'b1 || evict_valid === 1'b1) seen++;
      @(negedge clk);
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rst_dropped pulses=%0d expected 0", seen);
    end
    do_req(1'b0, 32'h0C0, 32'h0);
    n_checks++;
    if (r_hit !== 1'b0 || miss_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL rst_cleared hit=%b mc=%0d expected 0 1", r_hit, miss_cnt);
    end
    for (int i = 0; i < 14; i++) do_req(1'b0, 32'h2000 + 32'(i * 4), 32'h0);
    n_checks++;
    if (miss_cnt !== 4'd15) begin
      n_fail++;
      $display("FAIL cnt_reach_max mc=%0d expected 15", miss_cnt);
    end
    for (int i = 0; i < 3; i++) do_req(1'b0, 32'h3000, 32'h0);
    n_checks++;
    if (miss_cnt !== 4'd15 || hit_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL cnt_saturate mc=%0d hc=%0d expected 15 0", miss_cnt, hit_cnt);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_write_read();
    test_read_miss();
    test_evict();
    test_write_hit();
    test_flush();
    test_reset_mid_and_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
